// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: instruction kinds,
// opcode/funct values, run-control state codes and word-building helpers.
package instr_encoder_pkg;

    localparam int TYPE_W = 4;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;
    localparam int TGT_W  = 26;

    typedef enum logic [TYPE_W-1:0] {
        KIND_NOP  = 4'd0,
        KIND_ADDU = 4'd1,
        KIND_SUBU = 4'd2,
        KIND_JR   = 4'd3,
        KIND_J    = 4'd4,
        KIND_JAL  = 4'd5,
        KIND_BEQ  = 4'd6,
        KIND_ORI  = 4'd7,
        KIND_LUI  = 4'd8,
        KIND_LW   = 4'd9,
        KIND_SW   = 4'd10
    } instr_kind_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } instr_fields_t;

    function automatic logic [31:0] r_word(logic [REG_W-1:0] rs, logic [REG_W-1:0] rt,
                                           logic [REG_W-1:0] rd, logic [5:0] funct);
        return {OP_SPECIAL, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] op, logic [REG_W-1:0] rs,
                                           logic [REG_W-1:0] rt, logic [IMM_W-1:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(logic [5:0] op, logic [TGT_W-1:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Input beat channel and instruction-memory write port of the encoder.
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int IM_ADDR_W = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [TYPE_W-1:0]    in_type;
    logic [REG_W-1:0]     in_rs;
    logic [REG_W-1:0]     in_rt;
    logic [REG_W-1:0]     in_rd;
    logic [IMM_W-1:0]     in_imm;
    logic [TGT_W-1:0]     in_target;

    logic                 im_we;
    logic [IM_ADDR_W-1:0] im_addr;
    logic [31:0]          im_wdata;
    logic [31:0]          pc_out;

    modport master (
        output in_valid, in_type, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, im_we, im_addr, im_wdata, pc_out
    );

    modport slave (
        input  in_valid, in_type, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, im_we, im_addr, im_wdata, pc_out
    );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit MIPS word.
// Fields an encoding does not use are forced to zero; unknown kinds raise illegal_o.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [TYPE_W-1:0] kind_i,
    input  instr_fields_t     fields_i,
    output logic [31:0]       word_o,
    output logic              illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_NOP:  word_o = '0;
            KIND_ADDU: word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, FN_ADDU);
            KIND_SUBU: word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, FN_SUBU);
            KIND_JR:   word_o = r_word(fields_i.rs, '0, '0, FN_JR);
            KIND_J:    word_o = j_word(OP_J, fields_i.target);
            KIND_JAL:  word_o = j_word(OP_JAL, fields_i.target);
            KIND_BEQ:  word_o = i_word(OP_BEQ, fields_i.rs, fields_i.rt, fields_i.imm);
            KIND_ORI:  word_o = i_word(OP_ORI, fields_i.rs, fields_i.rt, fields_i.imm);
            KIND_LUI:  word_o = i_word(OP_LUI, '0, fields_i.rt, fields_i.imm);
            KIND_LW:   word_o = i_word(OP_LW, fields_i.rs, fields_i.rt, fields_i.imm);
            KIND_SW:   word_o = i_word(OP_SW, fields_i.rs, fields_i.rt, fields_i.imm);
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded MIPS words into instruction memory with an auto-incrementing
// write pointer, under a small IDLE/RUN/DRAIN/DONE session controller.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          IM_ADDR_W = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 finish,
    instr_encoder_if.slave       bus,
    output logic [IM_ADDR_W:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic                 err_illegal
);

    localparam logic [IM_ADDR_W:0] CAPACITY = {1'b1, {IM_ADDR_W{1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [IM_ADDR_W:0]   cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 we_q, we_d;
    logic [IM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          pc_q, pc_d;

    instr_fields_t        fields;
    logic [31:0]          packed_word;
    logic                 packed_illegal;
    logic                 accept;
    logic                 write_ok;
    logic                 restart;

    assign fields = '{rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                      imm: bus.in_imm, target: bus.in_target};

    instr_field_pack u_pack (
        .kind_i    (bus.in_type),
        .fields_i  (fields),
        .word_o    (packed_word),
        .illegal_o (packed_illegal)
    );

    // The pointer never wraps: once memory is full the channel stalls.
    assign bus.in_ready = (state_q == ST_RUN) && (cnt_q < CAPACITY);
    assign accept       = bus.in_valid && bus.in_ready;
    assign write_ok     = accept && !packed_illegal;

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (finish) state_d = ST_DRAIN;
            end
            // No beats are accepted here, so the only write in flight is the
            // one on the port this cycle; it retires at the coming edge.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = write_ok;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        if (restart) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
        if (write_ok) begin
            addr_d  = cnt_q[IM_ADDR_W-1:0];
            wdata_d = packed_word;
            pc_d    = BASE_ADDR + (32'(cnt_q[IM_ADDR_W-1:0]) << 2);
            cnt_d   = cnt_q + 1'b1;
        end
        if (accept && packed_illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign bus.pc_out   = pc_q;
    assign count        = cnt_q;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign err_illegal  = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a behavioural model
// of the load session (IM_ADDR_W=2 so the full-memory stall is reachable).
module tb_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic finish = 1'b0;
    logic [AW:0] count;
    logic busy, done, err_illegal;

    always #5 clk = ~clk;

    instr_encoder_if #(.IM_ADDR_W(AW)) bus ();

    instr_encoder #(.IM_ADDR_W(AW), .BASE_ADDR(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .finish      (finish),
        .bus         (bus),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal)
    );

    int errors = 0;
    int checks = 0;

    int          m_state = S_IDLE;
    int          m_cnt   = 0;
    bit          m_err   = 1'b0;
    bit          m_we    = 1'b0;
    int          m_addr  = 0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_pc    = '0;

    // Returns {illegal, word}, built straight from the MIPS field layout.
    function automatic logic [32:0] ref_encode(int t, int rs, int rt, int rd, int imm, int tgt);
        logic [31:0] w;
        logic [31:0] ri;
        ri = 32'((rs << 21) | (rt << 16) | (imm & 'hFFFF));
        case (t)
            0:  w = 32'h0;
            1:  w = 32'((rs << 21) | (rt << 16) | (rd << 11) | 'h21);
            2:  w = 32'((rs << 21) | (rt << 16) | (rd << 11) | 'h23);
            3:  w = 32'((rs << 21) | 'h08);
            4:  w = 32'h0800_0000 | 32'(tgt);
            5:  w = 32'h0C00_0000 | 32'(tgt);
            6:  w = 32'h1000_0000 | ri;
            7:  w = 32'h3400_0000 | ri;
            8:  w = 32'h3C00_0000 | 32'((rt << 16) | (imm & 'hFFFF));
            9:  w = 32'h8C00_0000 | ri;
            10: w = 32'hAC00_0000 | ri;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(bus.in_ready), 32'((m_state == S_RUN) && (m_cnt < CAP)));
        chk("im_we", 32'(bus.im_we), 32'(m_we));
        chk("im_addr", 32'(bus.im_addr), 32'(m_addr));
        chk("im_wdata", bus.im_wdata, m_data);
        chk("pc_out", bus.pc_out, m_pc);
        chk("count", 32'(count), 32'(m_cnt));
        chk("busy", 32'(busy), 32'((m_state == S_RUN) || (m_state == S_DRAIN)));
        chk("done", 32'(done), 32'(m_state == S_DONE));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
    endtask

    // Advance model and DUT one clock with the inputs currently driven.
    task automatic tick();
        logic [32:0] enc;
        bit acc;
        enc = ref_encode(int'(bus.in_type), int'(bus.in_rs), int'(bus.in_rt),
                         int'(bus.in_rd), int'(bus.in_imm), int'(bus.in_target));
        acc = bus.in_valid && (m_state == S_RUN) && (m_cnt < CAP);
        if (!reset) begin
            m_state = S_IDLE; m_cnt = 0; m_err = 1'b0;
            m_we = 1'b0; m_addr = 0; m_data = '0; m_pc = '0;
        end else begin
            m_we = acc && !enc[32];
            if (m_we) begin
                m_addr = m_cnt;
                m_data = enc[31:0];
                m_pc   = 32'h3000 + 32'(m_addr * 4);
                m_cnt++;
            end
            if (acc && enc[32]) m_err = 1'b1;
            case (m_state)
                S_IDLE, S_DONE: if (start) begin m_state = S_RUN; m_cnt = 0; m_err = 1'b0; end
                S_RUN:          if (finish) m_state = S_DRAIN;
                default:        m_state = S_DONE;
            endcase
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input int t, input int rs, input int rt, input int rd,
                        input int imm, input int tgt);
        bus.in_valid  = 1'b1;
        bus.in_type   = 4'(t);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_imm    = 16'(imm);
        bus.in_target = 26'(tgt);
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_type = '0; bus.in_rs = '0; bus.in_rt = '0;
        bus.in_rd = '0; bus.in_imm = '0; bus.in_target = '0;

        tick(); tick();
        reset = 1'b1;
        tick();

        // Back-to-back ADDU / ORI / LUI.
        pulse_start();
        send(1, 1, 2, 3, 0, 0);
        chk("addu_word", bus.im_wdata, 32'h0022_1821);
        chk("addu_pc", bus.pc_out, 32'h0000_3000);
        bus.in_valid = 1'b1;
        send(7, 0, 1, 0, 'h1234, 0);
        chk("ori_word", bus.im_wdata, 32'h3401_1234);
        chk("ori_pc", bus.pc_out, 32'h0000_3004);
        send(8, 0, 8, 0, 'hFFFF, 0);
        chk("lui_word", bus.im_wdata, 32'h3C08_FFFF);
        chk("lui_pc", bus.pc_out, 32'h0000_3008);
        tick();

        // Close the session, restart, then J / BEQ / SW with gaps.
        finish = 1'b1; tick(); finish = 1'b0; tick();
        chk("done_after_drain", 32'(done), 32'd1);
        pulse_start();
        chk("restart_count", 32'(count), 32'd0);
        send(4, 0, 0, 0, 0, 'hC00);
        chk("j_word", bus.im_wdata, 32'h0800_0C00);
        tick();
        chk("gap_we", 32'(bus.im_we), 32'd0);
        send(6, 1, 2, 0, 'hFFFF, 0);
        chk("beq_word", bus.im_wdata, 32'h1022_FFFF);
        chk("beq_addr", 32'(bus.im_addr), 32'd1);
        tick();
        send(10, 29, 31, 0, 4, 0);
        chk("sw_word", bus.im_wdata, 32'hAFBF_0004);
        chk("sw_addr", 32'(bus.im_addr), 32'd2);

        // Illegal kind between beats, then fill memory and stall.
        send(15, 3, 3, 3, 3, 3);
        chk("illegal_flag", 32'(err_illegal), 32'd1);
        chk("illegal_no_we", 32'(bus.im_we), 32'd0);
        send(2, 4, 5, 6, 0, 0);
        chk("after_illegal_addr", 32'(bus.im_addr), 32'd3);
        send(9, 1, 1, 0, 8, 0);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_stall_we", 32'(bus.im_we), 32'd0);
        finish = 1'b1; tick(); finish = 1'b0; tick();
        chk("full_done", 32'(done), 32'd1);
        chk("full_count", 32'(count), 32'd4);

        // finish together with the last beat.
        pulse_start();
        chk("restart_err", 32'(err_illegal), 32'd0);
        send(3, 31, 0, 0, 0, 0);
        finish = 1'b1;
        send(5, 0, 0, 0, 0, 'h3FF_FFFF);
        finish = 1'b0;
        chk("fin_beat_we", 32'(bus.im_we), 32'd1);
        chk("fin_beat_word", bus.im_wdata, 32'h0FFF_FFFF);
        tick();
        chk("fin_done", 32'(done), 32'd1);
        pulse_start();
        chk("fin_restart_count", 32'(count), 32'd0);

        // Reset while a write is pending.
        bus.in_valid = 1'b1;
        send(1, 7, 8, 9, 0, 0);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("rst_we", 32'(bus.im_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Randomized traffic, including start/finish collisions and resets.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_type   = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 11))
                                                     : 4'($urandom_range(10));
            bus.in_rs     = 5'($urandom);
            bus.in_rt     = 5'($urandom);
            bus.in_rd     = 5'($urandom);
            bus.in_imm    = 16'($urandom);
            bus.in_target = 26'($urandom);
            start  = ($urandom_range(7) == 0);
            finish = ($urandom_range(9) == 0);
            reset  = ($urandom_range(79) != 0);
            tick();
        end
        start = 1'b0; finish = 1'b0; reset = 1'b1; bus.in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
